// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: register-writer scoreboard beside the D stage.
// It tracks in-flight writers in a DEPTH-entry shift register that mirrors
// the E..W pipeline registers. From that it derives a stall request and a
// forward select for each of NREAD read ports.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   issue_valid/dst/tnew  D-stage writer (dst 0 never tracked)
//   flush               kill the D-stage instruction (E gets a bubble)
//   rd_addr, rd_tuse    per-port read address / cycles until value needed
//   stall               freeze PC and IF/ID, bubble into E
//   fwd_sel             per port: 0 = register file, k+1 = stage k
//   busy                per-stage valid-writer flags (debug)
//   stall_cnt, fwd_cnt  only present when FWD_STATS_EN is defined
//
// Optional feature macro: FWD_STATS_EN (stall / forward event counters).
module fwd_scoreboard #(
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int TW    = 2,
  parameter int SW    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_dst,
  input  logic [TW-1:0]         issue_tnew,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   rd_addr,
  input  logic [NREAD*TW-1:0]   rd_tuse,
  output logic                  stall,
  output logic [NREAD*SW-1:0]   fwd_sel,
  output logic [DEPTH-1:0]      busy
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           fwd_cnt
`endif
);

  // Stage entries: index 0 = E, DEPTH-1 = W.
  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][AW-1:0] dst_pipe;
  logic [DEPTH-1:0][TW-1:0] tnew_pipe;

  logic [NREAD-1:0]         stall_req;
  logic                     bubble;

  // A stalled or flushed D instruction must not enter E. When both are
  // high this is still just one bubble.
  assign bubble = stall | flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      dst_pipe  <= '0;
      tnew_pipe <= '0;
    end else begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        dst_pipe[k]  <= dst_pipe[k-1];
        tnew_pipe[k] <= (tnew_pipe[k-1] != '0) ? tnew_pipe[k-1] - TW'(1) : '0;
      end
      if (bubble) begin
        vld_pipe[0]  <= 1'b0;
        dst_pipe[0]  <= '0;
        tnew_pipe[0] <= '0;
      end else begin
        vld_pipe[0]  <= issue_valid && (issue_dst != '0);
        dst_pipe[0]  <= issue_dst;
        tnew_pipe[0] <= issue_tnew;
      end
    end
  end

  // Per-port hazard lane. The youngest matching stage wins. The loop runs
  // oldest-first, so the last hit written is the lowest k.
  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [AW-1:0] addr;
    logic [TW-1:0] tuse;
    logic          hit;
    logic [TW-1:0] m_tnew;
    logic [SW-1:0] m_sel;
    logic [SW-1:0] sel;
    logic          req;

    assign addr = rd_addr[i*AW +: AW];
    assign tuse = rd_tuse[i*TW +: TW];

    always_comb begin
      hit    = 1'b0;
      m_tnew = '0;
      m_sel  = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (vld_pipe[k] && dst_pipe[k] == addr && addr != '0) begin
          hit    = 1'b1;
          m_tnew = tnew_pipe[k];
          m_sel  = SW'(k + 1);
        end
      end
      sel = '0;
      req = 1'b0;
      if (hit) begin
        if (m_tnew == '0)      sel = m_sel;
        else if (m_tnew > tuse) req = 1'b1;
        // 0 < tnew <= tuse: a later stage select picks it up, no action now
      end
    end

    assign fwd_sel[i*SW +: SW] = sel;
    assign stall_req[i]        = req;
  end

  assign stall = |stall_req;
  assign busy  = vld_pipe;

  // A writer in the last tracked stage must have its result ready.
  a_last_stage_ready: assert property (@(posedge clk) disable iff (!reset_n)
    !(vld_pipe[DEPTH-1] && tnew_pipe[DEPTH-1] != '0));

`ifdef FWD_STATS_EN
  logic [31:0] nfwd;

  always_comb begin
    nfwd = '0;
    for (int i = 0; i < NREAD; i++)
      if (fwd_sel[i*SW +: SW] != '0) nfwd = nfwd + 32'd1;
  end

  // Forwards count only in non-stalled cycles; fwd_sel is don't-care under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      fwd_cnt   <= fwd_cnt + nfwd;
    end
  end
`else
  // Statistics disabled: no counters, hazard logic unchanged.
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (default parameters). The stimulus
// process drives one vector per cycle and pushes the expected outputs into
// a queue. The monitor pops one entry on each falling edge and compares.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dst = '0;
  logic [1:0]  issue_tnew = '0;
  logic        flush = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [3:0]  rd_tuse = '0;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [2:0]  busy;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic [31:0] sc0;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    string      nm;
    logic       st;
    logic [5:0] sel;
    logic [5:0] mask;
    logic [2:0] busy;
  } exp_t;

  exp_t q[$];

  fwd_scoreboard #(.NREAD(2), .DEPTH(3), .AW(5), .TW(2), .SW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_tnew(issue_tnew),
    .flush(flush), .rd_addr(rd_addr), .rd_tuse(rd_tuse),
    .stall(stall), .fwd_sel(fwd_sel), .busy(busy)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so they are sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (stall !== e.st) begin
          bad++;
          $display("FAIL %s stall: got %0b want %0b", e.nm, stall, e.st);
        end
        total++;
        if (busy !== e.busy) begin
          bad++;
          $display("FAIL %s busy: got %b want %b", e.nm, busy, e.busy);
        end
        total++;
        if ((fwd_sel & e.mask) !== (e.sel & e.mask)) begin
          bad++;
          $display("FAIL %s fwd_sel: got %o want %o (mask %o)", e.nm, fwd_sel, e.sel, e.mask);
        end
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, then queue the expectation.
  task automatic cyc(input string nm, input logic rn,
                     input logic iv, input logic [4:0] d, input logic [1:0] t,
                     input logic fl,
                     input logic [4:0] a0, input logic [1:0] u0,
                     input logic [4:0] a1, input logic [1:0] u1,
                     input logic es, input logic [2:0] s0, input logic [2:0] s1,
                     input logic [2:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n     = rn;
    issue_valid = iv;
    issue_dst   = d;
    issue_tnew  = t;
    flush       = fl;
    rd_addr     = {a1, a0};
    rd_tuse     = {u1, u0};
    e.nm   = nm;
    e.st   = es;
    e.sel  = {s1, s0};
    e.mask = es ? 6'o00 : 6'o77;
    e.busy = eb;
    q.push_back(e);
  endtask

  initial begin
    //   name          rn iv dst t  fl a0 u0 a1 u1  st s0 s1 busy
    cyc("rst_state",   0, 0, 0,  0, 0, 8, 0, 9, 0,  0, 0, 0, 3'b000);
    cyc("idle",        1, 0, 0,  0, 0, 8, 0, 9, 0,  0, 0, 0, 3'b000);
    // ALU to ALU
    cyc("alu_issue",   1, 1, 8,  1, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000);
    cyc("alu_e_later", 1, 0, 0,  0, 0, 8, 1, 0, 0,  0, 0, 0, 3'b001);
    cyc("alu_m_fwd",   1, 0, 0,  0, 0, 8, 1, 8, 0,  0, 2, 2, 3'b010);
    // load-use
    cyc("lw_issue_w",  1, 1, 9,  2, 0, 8, 0, 0, 0,  0, 3, 0, 3'b100);
    cyc("lu_stall1",   1, 0, 0,  0, 0, 9, 0, 8, 0,  1, 0, 0, 3'b001);
    cyc("lu_stall2",   1, 0, 0,  0, 0, 9, 0, 8, 0,  1, 0, 0, 3'b010);
    cyc("lu_w_fwd",    1, 0, 0,  0, 0, 9, 0, 8, 0,  0, 3, 0, 3'b100);
    // shadowing
    cyc("sh_issue1",   1, 1, 4,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000);
    cyc("sh_e_fwd",    1, 1, 4,  0, 0, 4, 0, 0, 0,  0, 1, 0, 3'b001);
    cyc("sh_e_over_m", 1, 0, 0,  0, 0, 4, 0, 4, 3,  0, 1, 1, 3'b011);
    cyc("sh_m_over_w", 1, 1, 0,  2, 0, 4, 0, 0, 0,  0, 2, 0, 3'b110);
    // zero register never tracked
    cyc("zero_reg",    1, 0, 0,  0, 0, 0, 0, 4, 0,  0, 0, 3, 3'b100);
    // flush during stall
    cyc("fl_issue",    1, 1, 10, 2, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000);
    cyc("fl_stall",    1, 1, 11, 0, 1, 10,0, 0, 0,  1, 0, 0, 3'b001);
`ifdef FWD_STATS_EN
    sc0 = stall_cnt;
`endif
    cyc("fl_one_bub",  1, 1, 12, 1, 0, 10,1, 0, 0,  0, 0, 0, 3'b010);
`ifdef FWD_STATS_EN
    total++;
    if (stall_cnt !== sc0 + 32'd1) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, sc0 + 32'd1);
    end
`endif
    cyc("fl_w_fwd",    1, 0, 0,  0, 0, 10,0, 12,1,  0, 3, 0, 3'b101);
    cyc("fl_m_fwd",    1, 0, 0,  0, 0, 0, 0, 12,0,  0, 0, 2, 3'b010);
    // flush alone
    cyc("flush_only",  1, 1, 13, 0, 1, 0, 0, 0, 0,  0, 0, 0, 3'b100);
    cyc("flush_gone",  1, 0, 0,  0, 0, 13,0, 0, 0,  0, 0, 0, 3'b000);
    // fill all three stages, then reset mid-stream
    cyc("fill1",       1, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000);
    cyc("fill2",       1, 1, 2,  0, 0, 1, 0, 0, 0,  0, 1, 0, 3'b001);
    cyc("fill3",       1, 1, 3,  0, 0, 1, 0, 2, 0,  0, 2, 1, 3'b011);
    cyc("full",        1, 0, 0,  0, 0, 3, 0, 1, 0,  0, 1, 3, 3'b111);
    cyc("async_rst",   0, 0, 0,  0, 0, 3, 0, 1, 0,  0, 0, 0, 3'b000);
    cyc("post_rst",    1, 0, 0,  0, 0, 3, 0, 1, 0,  0, 0, 0, 3'b000);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
